bfm_apbslave_mem: RTL and testbench
===================================

BFM_APBSLAVE_MEM -- requirements
Module: bfm_apbslave_mem

Interface
REQ-001 SHALL have parameters (name, default, meaning): AWIDTH, 8, word-address bits (DEPTH = 2**AWIDTH words of 32 bits).
REQ-002 SHALL have parameter WAITS, 0, wait cycles inserted in every access phase (0..15).
REQ-003 SHALL have parameter TPD, 1, delay (ns) on all outputs.
REQ-004 SHALL have ports (name, direction, width, meaning):
- HCLK, in, 1, clock.
- HRESETN, in, 1, reset.
- PSEL, in, 1, slave select (one bit of the bridge PSEL vector).
- PENABLE, in, 1, access phase.
- PWRITE, in, 1, 1 = write.
- PADDR, in, 32, byte address; only PADDR[23:0] is decoded.
- PWDATA, in, 32, write data.
- PRDATA, out, 32, read data.
- PREADY, out, 1, transfer complete.
- PSLVERR, out, 1, transfer error.
- XFERCNT, out, 16, completed-transfer count.
REQ-005 SHALL use reset HRESETN (asynchronous, active-low) and clock HCLK; all state changes on rising HCLK.

Function
REQ-006 SHALL implement an FSM with states IDLE, ACCESS.
REQ-007 IDLE->ACCESS SHALL occur on an edge sampling PSEL=1 and PENABLE=0 (setup); at that edge the block SHALL:
- load the wait counter with WAITS;
- latch PADDR[23:0] and PWRITE;
- evaluate error = (PADDR[23:AWIDTH+2] != 0).
REQ-008 PRDATA SHALL be loaded at the setup edge with mem[PADDR[AWIDTH+1:2]] for an in-range read, 0 otherwise, and SHALL hold its value until the next setup edge.
REQ-009 In ACCESS, the counter SHALL decrement by 1 per cycle while nonzero; PREADY SHALL be 1 exactly when state=ACCESS and counter=0, decoded from registers only (no combinational input path).
REQ-010 With WAITS=0, PREADY SHALL assert in the first access cycle, giving a 2-cycle transfer; WAITS=N SHALL give N+2 cycles.
REQ-011 PSLVERR SHALL equal PREADY AND latched error; otherwise 0.
REQ-012 At the edge where PREADY=1, PSEL=1 and PENABLE=1:
- state SHALL return to IDLE;
- if latched write and no error, mem[latched word index] SHALL be written with the PWDATA sampled at that edge;
- XFERCNT SHALL increment by 1 (error transfers included), wrapping 0xFFFF->0x0000.
REQ-013 An erroneous write SHALL leave memory unchanged.
REQ-014 If PSEL=0 in ACCESS before completion, the block SHALL abort to IDLE without a write or XFERCNT increment.
REQ-015 In IDLE, PSEL=1 with PENABLE=1 (no setup) SHALL be ignored: the block stays in IDLE with PREADY=0.
REQ-016 Back-to-back transfers SHALL be supported: a setup in the cycle after completion SHALL be accepted normally.
REQ-017 A read whose setup follows a completed write to the same word SHALL return the new data.
REQ-018 The block SHALL treat PADDR[1:0] as don't-care and perform full-word accesses only.

Reset
REQ-019 While HRESETN=0, the block SHALL hold:
- state = IDLE, counter = 0;
- PRDATA = 0, PREADY = 0, PSLVERR = 0, XFERCNT = 0;
- all memory words = 0.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer immediately with no memory write.
REQ-021 The first setup SHALL be accepted on the first rising edge after HRESETN deasserts.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Write 0xDEADBEEF to 0x00000010, then read 0x00000010 (WAITS=0) -> PREADY high in the second cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0; XFERCNT=2.
- WAITS=3, read 0x4 -> PREADY low for 3 access cycles then high; transfer is 5 cycles total.
- Write 0x12345678 to 0x00000400 (AWIDTH=8, out of range) -> PSLVERR=1 with PREADY; a following read of word 0 returns 0; XFERCNT increments.
- Write 0xA5A5A5A5 to 0x8, with PSEL dropped in the access phase while WAITS=2 -> FSM returns to IDLE; a read of 0x8 returns 0; XFERCNT unchanged.
- HRESETN pulsed low during a wait state after a write to 0xC -> all outputs 0; a read of 0xC returns 0.
- Behind the AHB-to-APB bridge, HSEL burst of 4 writes then 4 reads at 0x0..0xC -> data matches, no HRESP error, XFERCNT=8.

Source files
------------

// File: rtl/bfm_apbslave_mem.sv
// APB slave memory model: 2**AWIDTH words of 32 bits behind a two-state
// IDLE/ACCESS controller with a fixed number of wait states per transfer.
//
// Parameters:
//   AWIDTH - word-address bits (DEPTH = 2**AWIDTH words)
//   WAITS  - wait cycles inserted in every access phase (0..15, larger values clamp to 15)
//   TPD    - nominal output delay in ns; kept for compatibility with the timed model,
//            outputs here change directly at the rising HCLK edge
//
// Ports:
//   HCLK, HRESETN  - clock, asynchronous active-low reset
//   PSEL, PENABLE  - APB select / access-phase strobe
//   PWRITE, PADDR  - direction and byte address (PADDR[23:0] decoded, [1:0] ignored)
//   PWDATA         - write data, sampled at the completing edge
//   PRDATA         - read data, loaded at the setup edge and held until the next setup
//   PREADY         - transfer complete (registered decode only)
//   PSLVERR        - error response, qualified by PREADY
//   XFERCNT        - count of completed transfers (wraps)
module bfm_apbslave_mem #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned WAITS  = 0,
  parameter int unsigned TPD    = 1
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] XFERCNT
);

  localparam int unsigned Depth    = 2 ** AWIDTH;
  localparam logic [3:0]  WaitLoad = (WAITS > 15) ? 4'd15 : 4'(WAITS);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   idx_q, idx_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [31:0]         prdata_q, prdata_d;
  logic [15:0]         xfercnt_q, xfercnt_d;
  logic [31:0]         mem_q [Depth];
  logic                mem_we;
  logic                ready;
  logic [AWIDTH-1:0]   setup_idx;
  logic                setup_err;

  // Address bits outside the decoded window and the delay parameter carry no logic.
  logic [41:0] unused_bits;
  assign unused_bits = {PADDR[31:24], PADDR[1:0], 32'(TPD)};

  assign setup_idx = PADDR[AWIDTH+1:2];
  assign setup_err = |PADDR[23:AWIDTH+2];

  // Registered decode only, so PREADY has no combinational path from the bus.
  assign ready = (state_q == StAccess) && (cnt_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    xfercnt_d = xfercnt_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // PSEL with PENABLE already high is not a setup and is ignored.
        if (PSEL && !PENABLE) begin
          state_d  = StAccess;
          cnt_d    = WaitLoad;
          idx_d    = setup_idx;
          write_d  = PWRITE;
          err_d    = setup_err;
          prdata_d = (!PWRITE && !setup_err) ? mem_q[setup_idx] : 32'd0;
        end
      end
      StAccess: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (ready) begin
          if (PENABLE) begin
            state_d   = StIdle;
            mem_we    = write_q && !err_q;
            xfercnt_d = xfercnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= 32'd0;
      xfercnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      xfercnt_q <= xfercnt_d;
    end
  end

  // Memory clears on reset; a reset during a transfer therefore never writes.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      mem_q <= '{default: 32'd0};
    end else if (mem_we) begin
      mem_q[idx_q] <= PWDATA;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = ready;
  assign PSLVERR = ready && err_q;
  assign XFERCNT = xfercnt_q;

endmodule

// File: tb/tb_bfm_apbslave_mem.sv
// Directed bench for bfm_apbslave_mem. Three instances differ only in WAITS
// (0, 2, 3) and share clock and reset. Expected read data and error flags are
// queued at setup and popped when PREADY is seen.
module tb_bfm_apbslave_mem;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [2:0]        psel, penable, pwrite;
  logic [2:0][31:0]  paddr, pwdata, prdata;
  logic [2:0]        pready, pslverr;
  logic [2:0][15:0]  xfercnt;

  exp_t        sb[$];
  logic [31:0] mem_m [3][256];
  logic [15:0] xcnt_m [3];
  int          n_vec;
  int          n_bad;

  bfm_apbslave_mem #(.AWIDTH(8), .WAITS(0), .TPD(1)) u_dut0 (
    .HCLK(clk), .HRESETN(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .XFERCNT(xfercnt[0])
  );

  bfm_apbslave_mem #(.AWIDTH(8), .WAITS(2), .TPD(1)) u_dut2 (
    .HCLK(clk), .HRESETN(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .XFERCNT(xfercnt[1])
  );

  bfm_apbslave_mem #(.AWIDTH(8), .WAITS(3), .TPD(1)) u_dut3 (
    .HCLK(clk), .HRESETN(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .XFERCNT(xfercnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int waits_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      xcnt_m[k] = 16'd0;
      for (int w = 0; w < 256; w++) mem_m[k][w] = 32'd0;
    end
  endtask

  // Called anywhere between edges; leaves the bench 1 ns after the completing edge
  // so a following call produces a back-to-back setup.
  task automatic apb_xfer(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
    exp_t       e;
    int         n;
    logic       err;
    logic [7:0] idx;
    err     = (addr[23:10] != 14'd0);
    idx     = addr[9:2];
    e.rdata = (!wr && !err) ? mem_m[k][idx] : 32'd0;
    e.err   = err;
    sb.push_back(e);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = data;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pready[k] !== 1'b1 && n < 40);
    check({tag, " cycles"}, 32'(n + 1), 32'(waits_of(k) + 2));
    e = sb.pop_front();
    check({tag, " prdata"}, prdata[k], e.rdata);
    check({tag, " pslverr"}, {31'd0, pslverr[k]}, {31'd0, e.err});
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
    if (wr && !err) mem_m[k][idx] = data;
    xcnt_m[k] = xcnt_m[k] + 16'd1;
    check({tag, " xfercnt"}, {16'd0, xfercnt[k]}, {16'd0, xcnt_m[k]});
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    clear_model();
    rst_n = 1'b0;

    // Reset state
    #2;
    check("rst prdata", prdata[0], 32'd0);
    check("rst pready", {31'd0, pready[0]}, 32'd0);
    check("rst pslverr", {31'd0, pslverr[0]}, 32'd0);
    check("rst xfercnt", {16'd0, xfercnt[0]}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back-to-back, zero waits; setup accepted on first edge after reset
    apb_xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "w10");
    apb_xfer(0, 1'b0, 32'h0000_0010, 32'h0, "r10");

    // Out-of-range write errors and leaves word 0 (its alias) untouched
    apb_xfer(0, 1'b1, 32'h0000_0400, 32'h1234_5678, "werr");
    apb_xfer(0, 1'b0, 32'h0000_0000, 32'h0, "r00");
    // Address bits 1:0 are ignored
    apb_xfer(0, 1'b1, 32'h0000_0023, 32'h0BAD_F00D, "w20b");
    apb_xfer(0, 1'b0, 32'h0000_0020, 32'h0, "r20");

    // PSEL with PENABLE in idle is not a setup
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h4;
    @(negedge clk);
    check("nosetup pready1", {31'd0, pready[0]}, 32'd0);
    @(negedge clk);
    check("nosetup pready2", {31'd0, pready[0]}, 32'd0);
    check("nosetup xfercnt", {16'd0, xfercnt[0]}, {16'd0, xcnt_m[0]});
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;

    // Three wait states: five-cycle read
    apb_xfer(2, 1'b0, 32'h0000_0004, 32'h0, "w3r04");

    // Abort in the access phase with WAITS=2
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h8; pwdata[1] = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    check("abort pready", {31'd0, pready[1]}, 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    check("abort pready idle", {31'd0, pready[1]}, 32'd0);
    check("abort xfercnt", {16'd0, xfercnt[1]}, {16'd0, xcnt_m[1]});
    apb_xfer(1, 1'b0, 32'h0000_0008, 32'h0, "abort r08");

    // Leave non-zero read data on instance 0 so the reset clear is visible
    apb_xfer(0, 1'b0, 32'h0000_0010, 32'h0, "r10b");

    // Reset during a wait state of a write to 0xC
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'hC; pwdata[2] = 32'h55AA_55AA;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    check("rstmid pready", {31'd0, pready[2]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid prdata0", prdata[0], 32'd0);
    check("rstmid xfercnt0", {16'd0, xfercnt[0]}, 32'd0);
    check("rstmid xfercnt3", {16'd0, xfercnt[2]}, 32'd0);
    check("rstmid pready3", {31'd0, pready[2]}, 32'd0);
    check("rstmid pslverr3", {31'd0, pslverr[2]}, 32'd0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    apb_xfer(2, 1'b0, 32'h0000_000C, 32'h0, "rstmid r0c");

    // Bridge-style burst: four writes then four reads, back-to-back
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, 1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i * 32'h1111), $sformatf("bw%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, 1'b0, 32'(i * 4), 32'h0, $sformatf("br%0d", i));
    end
    check("burst xfercnt8", {16'd0, xfercnt[0]}, 32'd8);
    // Memory cleared by reset
    apb_xfer(0, 1'b0, 32'h0000_0010, 32'h0, "r10 after rst");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
